axi_lite_master: RTL
====================

# axi_lite_master

Single-outstanding AXI4-Lite initiator that turns a simple command/response handshake into register reads and writes on the LPDDR4 control register bus. It sits between on-chip sequencing logic (bring-up FSMs, memtest control) and the register-file slave, so that hardware can program resets, memtest parameters and tester patterns, and poll status, without a soft CPU. One transaction is in flight at a time. An optional watchdog recovers from a slave that never responds.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; strobe width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 1024, watchdog limit in axi_aclk cycles per transaction phase (only used with the timeout macro)

Ports:
- axi_aclk  in  1  clock
- axi_resetn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP captured from slave
- rsp_timeout  out  1  transaction aborted by watchdog
- axi_awaddr/awvalid/awready  out/out/in  ADDR_WIDTH/1/1  AW channel
- axi_wdata/wstrb/wvalid/wlast/wready  out/out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1/1  W channel; wlast tied 1
- axi_bresp/bvalid/bready  in/in/out  2/1/1  B channel
- axi_araddr/arvalid/arready  out/out/in  ADDR_WIDTH/1/1  AR channel
- axi_rdata/rresp/rvalid/rlast/rready  in/in/in/in/out  DATA_WIDTH/2/1/1/1  R channel; rlast ignored

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. On accept, latch addr/wdata/wstrb. Go to WR_REQ if cmd_write=1, else RD_REQ.
- WR_REQ: awvalid and wvalid both asserted. Each drops independently on its own handshake. Go to WR_RESP once both handshakes complete; they may complete in the same or different cycles.
- WR_RESP: bready=1. On bvalid, capture bresp and go to RSP.
- RD_REQ: arvalid=1. On arready, go to RD_RESP.
- RD_RESP: rready=1. On rvalid, capture rdata and rresp and go to RSP.
- RSP: rsp_valid=1, with rsp_* held stable until rsp_ready, then return to IDLE. Commands are never accepted while rsp_valid=1.
- Address and data outputs are registered and held stable while the matching valid is high. Addresses are passed unmodified; the slave decodes [ADDR_WIDTH-1:2].
- Valids, once asserted, are never withdrawn before their handshake, except on watchdog abort.
- Reset mid-transaction: all valid/ready outputs drop immediately (asynchronous reset). State returns to IDLE and any pending response is lost.

## Timing
- Reset values: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, all AXI valid/ready outputs=0, addr/data/strb outputs=0, wlast=1.
- cmd_ready rises on the first clock edge after axi_resetn deasserts.
- Accept at edge N: request valid(s) high from cycle N+1.
- Against an always-ready slave that responds one cycle after the data handshake:
  - write: AW/W handshake at N+1, bvalid at N+2, rsp_valid from N+3;
  - read: AR handshake at N+1, rvalid at N+2 or later, rsp_valid the cycle after the R handshake.
- Back-to-back: a new command can be accepted the cycle after the rsp_valid&rsp_ready handshake.
- rsp_valid&rsp_ready in the same cycle as cmd_valid: the command is not accepted that cycle.

## Configuration
- AXI_LITE_MASTER_TIMEOUT_EN defined: a phase counter clears on entry to WR_REQ, WR_RESP, RD_REQ and RD_RESP, and increments every cycle while in that state.
  - On reaching TIMEOUT_CYCLES, all AXI valids/readies drop and the block goes to RSP with rsp_timeout=1, rsp_resp=2'b10 (SLVERR) and rsp_rdata=0.
  - A handshake in the same cycle as expiry wins; no timeout is reported.
- Undefined: no counter; rsp_timeout is tied 0 and the block waits indefinitely.

## Structure
- Shared package: state encoding enum, AXI response constants (OKAY=2'b00, SLVERR=2'b10), and the default TIMEOUT_CYCLES.
- Single module. The watchdog is an inline counter with no sub-module. The counter width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Write 0x0000001F to 0x0C, always-ready slave, OKAY response -> awaddr=0x0C and wdata=0x1F with wstrb=0xF on cycle N+1; rsp_valid on N+3 with rsp_resp=0, rsp_timeout=0.
- Read 0x04, slave returns 0x00000003 after 5-cycle rvalid delay -> rready held high throughout; rsp_rdata=0x3.
- Write with awready held low 3 cycles and wready immediate -> wvalid high for 1 cycle, awvalid high for 4 cycles with stable awaddr; exactly one bready handshake.
- rsp_ready held low 10 cycles with cmd_valid high -> rsp_* stable and cmd_ready=0 throughout; the next command is accepted the cycle after the response handshake.
- Timeout macro on, TIMEOUT_CYCLES=16, slave never asserts bvalid -> after 16 cycles in WR_RESP, bready drops and rsp_valid=1 with rsp_timeout=1, rsp_resp=2'b10.
- axi_resetn pulsed low during RD_RESP -> rready=0 and rsp_valid=0 immediately; cmd_ready=1 one edge after release; a following read completes normally.

Source files
------------

// File: rtl/axi_lite_master_pkg.sv
// Shared definitions for axi_lite_master: FSM state encoding, AXI response codes
// and the default watchdog limit.
package axi_lite_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_RSP
  } alm_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator driven by a cmd/rsp handshake.
// Define AXI_LITE_MASTER_TIMEOUT_EN to enable the per-phase watchdog abort.
module axi_lite_master
  import axi_lite_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                    axi_aclk,
  input  logic                    axi_resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wvalid,
  output logic                    axi_wlast,
  input  logic                    axi_wready,
  input  logic [1:0]              axi_bresp,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rvalid,
  input  logic                    axi_rlast,
  output logic                    axi_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;

  alm_state_e            state_q;
  logic                  cmd_ready_q, rsp_valid_q, rsp_timeout_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [1:0]            resp_q;
  logic                  aw_done, w_done, expire;
  logic                  unused_sig;

  // A channel whose valid already dropped counts as complete.
  assign aw_done = !awvalid_q || axi_awready;
  assign w_done  = !wvalid_q || axi_wready;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] wd_q;
  logic             in_phase, phase_done;

  assign in_phase   = (state_q != ST_IDLE) && (state_q != ST_RSP);
  assign phase_done = ((state_q == ST_WR_REQ)  && aw_done && w_done) ||
                      ((state_q == ST_WR_RESP) && axi_bvalid) ||
                      ((state_q == ST_RD_REQ)  && axi_arready) ||
                      ((state_q == ST_RD_RESP) && axi_rvalid);
  // A handshake landing on the expiry cycle takes priority over the abort.
  assign expire     = in_phase && !phase_done && (wd_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wd_q <= '0;
    end else if (!in_phase || phase_done) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + TMO_W'(1);
    end
  end

  assign unused_sig = axi_rlast;
`else
  assign expire     = 1'b0;
  assign unused_sig = ^{axi_rlast, (TIMEOUT_CYCLES > 0)};
`endif

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rdata_q       <= '0;
      resp_q        <= RESP_OKAY;
    end else if (expire) begin
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rdata_q       <= '0;
      resp_q        <= RESP_SLVERR;
      rsp_timeout_q <= 1'b1;
      rsp_valid_q   <= 1'b1;
      state_q       <= ST_RSP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            wstrb_q     <= cmd_wstrb;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (axi_awready) awvalid_q <= 1'b0;
          if (axi_wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (axi_bvalid) begin
            bready_q      <= 1'b0;
            resp_q        <= axi_bresp;
            rdata_q       <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RSP;
          end
        end
        ST_RD_REQ: begin
          if (axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (axi_rvalid) begin
            rready_q      <= 1'b0;
            rdata_q       <= axi_rdata;
            resp_q        <= axi_rresp;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RSP;
          end
        end
        ST_RSP: begin
          // Returning with cmd_ready already set allows accept on the very next edge.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = rsp_timeout_q;
  assign axi_awaddr  = addr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_wlast   = 1'b1;
  assign axi_bready  = bready_q;
  assign axi_araddr  = addr_q;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;

endmodule
